// File: rtl/sdiv_q8_8_if.sv
// ============================================================================
// Module   : sdiv_q8_8_if
// Purpose  : Handshake and operand bundle for the Q8.8 sequential divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdiv_q8_8_if #(
  parameter int WIDTH = 16
);
  logic                    start;
  logic                    current_phase;
  logic                    expected_phase;
  logic signed [WIDTH-1:0] A;
  logic signed [WIDTH-1:0] B;
  logic signed [WIDTH-1:0] C;
  logic                    busy;
  logic                    done;
  logic                    div_by_zero;

  modport master (
    output start, current_phase, expected_phase, A, B,
    input  C, busy, done, div_by_zero
  );

  modport slave (
    input  start, current_phase, expected_phase, A, B,
    output C, busy, done, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/sdiv_q8_8.sv
// ============================================================================
// Module   : sdiv_q8_8
// Purpose  : Phase-gated signed Q8.8 restoring divider, one quotient bit per
//            cycle, with saturation and divide-by-zero flagging.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdiv_q8_8 #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  wire logic     CLK,
  input  wire logic     RST,
  sdiv_q8_8_if.slave    bus
);
  localparam int NW = WIDTH + 1 + FRAC;
  localparam int CW = $clog2(NW);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_calc = 2'd1;
  localparam logic [1:0] c_fix  = 2'd2;

  localparam logic [CW-1:0]    c_last    = CW'(NW - 1);
  localparam logic [NW-1:0]    c_max_pos = {{(NW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [NW-1:0]    c_max_neg = {{(NW-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_sat_pos = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_sat_neg = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]      r_state;
  logic            r_sign;
  logic            r_a_neg;
  logic            r_dz;
  logic [WIDTH:0]  r_mag_b;
  logic [NW-1:0]   r_num;
  logic [WIDTH:0]  r_rem;
  logic [CW-1:0]   r_count;

  logic            w_accept;
  logic            w_b_zero;
  logic [WIDTH:0]  w_a_ext;
  logic [WIDTH:0]  w_b_ext;
  logic [WIDTH:0]  w_mag_a;
  logic [WIDTH:0]  w_mag_b;
  logic [WIDTH+1:0] w_rem_sh;
  logic            w_ge;
  logic [WIDTH:0]  w_rem_next;
  logic [WIDTH-1:0] w_q_lo;
  logic [WIDTH-1:0] w_result;

  assign bus.busy = (r_state != c_idle);
  assign w_accept = bus.start && !bus.busy && (bus.current_phase == bus.expected_phase);
  assign w_b_zero = (bus.B == '0);

  // One extra bit of magnitude keeps -2^(WIDTH-1) exact after negation.
  assign w_a_ext = {bus.A[WIDTH-1], bus.A};
  assign w_b_ext = {bus.B[WIDTH-1], bus.B};
  assign w_mag_a = bus.A[WIDTH-1] ? -w_a_ext : w_a_ext;
  assign w_mag_b = bus.B[WIDTH-1] ? -w_b_ext : w_b_ext;

  // The dividend shifts out of r_num while quotient bits shift in behind it.
  assign w_rem_sh   = {r_rem, r_num[NW-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_mag_b});
  assign w_rem_next = w_ge ? (w_rem_sh[WIDTH:0] - r_mag_b) : w_rem_sh[WIDTH:0];

  assign w_q_lo = r_num[WIDTH-1:0];

  always_comb begin
    w_result = w_q_lo;
    if (r_dz) begin
      w_result = r_a_neg ? c_sat_neg : c_sat_pos;
    end else if (r_sign) begin
      w_result = (r_num > c_max_neg) ? c_sat_neg : -w_q_lo;
    end else if (r_num > c_max_pos) begin
      w_result = c_sat_pos;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state         <= c_idle;
      r_sign          <= 1'b0;
      r_a_neg         <= 1'b0;
      r_dz            <= 1'b0;
      r_mag_b         <= '0;
      r_num           <= '0;
      r_rem           <= '0;
      r_count         <= '0;
      bus.C           <= '0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (r_state)
        c_idle: begin
          if (w_accept) begin
            r_sign          <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            r_a_neg         <= bus.A[WIDTH-1];
            r_dz            <= w_b_zero;
            r_mag_b         <= w_mag_b;
            r_num           <= {w_mag_a, {FRAC{1'b0}}};
            r_rem           <= '0;
            r_count         <= '0;
            bus.div_by_zero <= 1'b0;
            r_state         <= w_b_zero ? c_fix : c_calc;
          end
        end
        c_calc: begin
          r_rem   <= w_rem_next;
          r_num   <= {r_num[NW-2:0], w_ge};
          r_count <= r_count + 1'b1;
          if (r_count == c_last) begin
            r_state <= c_fix;
          end
        end
        c_fix: begin
          bus.C           <= w_result;
          bus.done        <= 1'b1;
          bus.div_by_zero <= r_dz;
          r_state         <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: doc/sdiv_q8_8.md
# sdiv_q8_8

Sequential signed Q8.8 fixed-point divider. It computes C = A / B over 16-bit two's-complement operands with 8 fractional bits, and is the inverse of the datapath's Q8.8 multiplier stage. Like the multiplier, it is phase-gated: an operation is accepted only when `current_phase == expected_phase`. It uses a radix-2 restoring algorithm with one quotient bit per cycle, saturating output and divide-by-zero flagging, and serves the normalisation and scaling steps that must undo multiplies.

## Interface
- `WIDTH`, default 16: operand and result width, two's complement.
- `FRAC`, default 8: fractional bits in operands and result.
- `CLK`, input, 1: sole clock; all state updates on the rising edge.
- `RST`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a divide; sampled each rising edge.
- `current_phase`, input, 1: present phase of the schedule.
- `expected_phase`, input, 1: phase this instance serves.
- `A`, input, WIDTH, signed: dividend (Q8.8).
- `B`, input, WIDTH, signed: divisor (Q8.8).
- `C`, output reg, WIDTH, signed: quotient (Q8.8); holds the last result.
- `busy`, output, 1: high whenever the FSM is not in IDLE.
- `done`, output reg, 1: one-cycle pulse when `C` has been updated.
- `div_by_zero`, output reg, 1: set together with `done` when B == 0; cleared at the next accept.

## Operation
- Accept condition: `start && !busy && (current_phase == expected_phase)`. A `start` that misses any of these terms is ignored and leaves no pending request.
- On accept, the block captures:
  - sign = A[MSB] ^ B[MSB]
  - |A| and |B| as (WIDTH+1)-bit magnitudes, so -32768 is exact
  - numerator N = |A| << FRAC, 25 bits
  - remainder R = 0, count = 0
- Operands are captured at accept. Later changes to `A`, `B` or the phase inputs do not affect the operation in flight.
- FSM states:
  - IDLE: waits for an accept. Goes to CALC when B != 0, or to FIX with the zero flag set when B == 0.
  - CALC: 25 iterations. Each iteration does R' = {R, N[MSB]}, N <<= 1. If R' >= |B|, then R = R' - |B| and quotient bit = 1; otherwise R = R' and the bit is 0. After the 25th iteration it goes to FIX.
  - FIX: applies sign and saturation, writes `C`, pulses `done`, then goes to IDLE.
- Rounding: the quotient magnitude Q (25 bits) is truncated toward zero. The remainder is discarded.
- Saturation:
  - Positive result with Q > 32767 gives C = 16'h7FFF.
  - Negative result with Q > 32768 gives C = 16'h8000.
  - Otherwise C = sign ? -Q[15:0] : Q[15:0].
- Divide by zero:
  - C = 16'h7FFF when A >= 0, and C = 16'h8000 when A < 0; 0/0 gives 16'h7FFF.
  - `div_by_zero` = 1.
  - No CALC iterations run.
- `C` changes only in FIX and on reset.

## Timing
- Reset values: `C` = 0, `done` = 0, `div_by_zero` = 0, `busy` = 0, state IDLE, internal registers = 0.
- Let accept happen at edge k.
  - Normal divide: `busy` = 1 from after edge k through edge k+26. CALC occupies edges k+1..k+25 and FIX is edge k+26. `C` and `done` are valid after edge k+26, `done` drops after k+27, and `busy` is 0 after edge k+26.
  - Divide by zero: FIX at edge k+1, with `C`, `done` and `div_by_zero` valid after that edge. Latency is 1 cycle.
- Back-to-back operation: a new accept is possible in the cycle in which `done` is high, because `busy` is already 0. That gives a throughput of one result per 27 cycles.
- `start` held high with the phase matching produces a new operation on every cycle where `busy` = 0.
- Reset mid-operation (`RST` high at any edge) aborts the operation, returns to IDLE and applies all reset values. No `done` is issued for the aborted operation.
- `RST` and `start` asserted on the same edge: reset wins and nothing is accepted.

## Test plan
- Basic positive and negative divides:
  - A=16'h0300 (3.0), B=16'h0200 (2.0), phases equal, `start` pulse -> C=16'h0180, `done` exactly 26 cycles after accept, `div_by_zero`=0.
  - A=16'hFD00 (-3.0), B=16'h0200 -> C=16'hFE80.
  - A=16'h8000, B=16'h0100 -> C=16'h8000, exact and not saturated.
- Truncation toward zero:
  - A=16'h0100, B=16'h0300 -> C=16'h0055.
  - A=16'hFF00, B=16'h0300 -> C=16'hFFAB.
- Saturation:
  - A=16'h7F00, B=16'h0080 -> C=16'h7FFF.
  - A=16'h8000, B=16'hFF00 -> C=16'h7FFF.
  - A=16'h8000, B=16'h0080 -> C=16'h8000.
- Divide by zero:
  - A=16'h0100, B=0 -> after 1 cycle C=16'h7FFF, `div_by_zero`=1, `done` for one cycle.
  - A=16'hFF00, B=0 -> C=16'h8000.
  - A following normal divide -> `div_by_zero` returns to 0.
- Gating:
  - `start` with current_phase != expected_phase -> no `busy`, `C` unchanged.
  - `start` while `busy`, with `A`/`B` changed mid-CALC -> ignored; result matches the captured operands.
- Reset:
  - `RST` asserted at CALC iteration 10 -> next cycle `busy`=0, `C`=0, no `done`.
  - A fresh divide afterwards completes with correct latency and value.
